// File: rtl/mc_ctrl_irq.sv
// ============================================================================
//  Module      : mc_ctrl_irq
//  Description : Multicycle MIPS control FSM. Decodes the IR, sequences
//                FETCH..WB with a memory ready handshake, takes maskable
//                interrupts at instruction boundaries and drives the
//                datapath strobes and mux selects.
//  Option      : define RI_TRAP_EN to trap undecoded opcodes into EXC
//                (exc_code=10, EPC = faulting PC). Without it an undecoded
//                opcode returns to FETCH silently.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_ctrl_irq #(
    parameter int NIRQ       = 6,
    parameter int EXC_CODE_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           i_instr,
    input  logic                  i_zero,
    input  logic [NIRQ-1:0]       i_irq,
    input  logic [NIRQ-1:0]       i_irq_mask,
    input  logic                  i_ie,
    input  logic                  i_exl,
    input  logic                  i_mem_ready,
    output logic [3:0]            o_state,
    output logic                  o_pc_wr,
    output logic                  o_ir_wr,
    output logic                  o_reg_wr,
    output logic                  o_cp0_we,
    output logic                  o_epc_wr,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [1:0]            o_mem_size,
    output logic [1:0]            o_reg_dst,
    output logic [1:0]            o_wb_sel,
    output logic                  o_alu_src,
    output logic [2:0]            o_alu_op,
    output logic [1:0]            o_ext_op,
    output logic [2:0]            o_pc_sel,
    output logic                  o_epc_sel,
    output logic                  o_exl_set,
    output logic                  o_exl_clr,
    output logic [EXC_CODE_W-1:0] o_exc_code
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MADDR  = 4'd2,
        S_MREAD  = 4'd3,
        S_MWB    = 4'd4,
        S_MWRITE = 4'd5,
        S_EXE    = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_INT    = 4'd10,
        S_EXC    = 4'd11
    } state_t;

    state_t r_state;

    // ------------------------------------------------------------------
    // Instruction decode (IR is stable from DECODE to the end of the
    // instruction, so it is decoded directly without a local copy)
    // ------------------------------------------------------------------
    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rs;
    logic       w_rtype;
    logic       w_addu, w_subu, w_slt, w_jr;
    logic       w_ori, w_lui, w_addi, w_addiu;
    logic       w_lw, w_lh, w_lb, w_sw, w_sh, w_sb;
    logic       w_beq, w_bne, w_j, w_jal;
    logic       w_cop0, w_mfc0, w_mtc0, w_eret;
    logic       w_load, w_store, w_alu_r, w_alu_i;
    logic       w_irq_pend;
    logic [1:0] w_mem_size;
    logic [2:0] w_alu_op;
    logic [1:0] w_ext_op;
    logic       w_unused_instr;

    assign w_op    = i_instr[31:26];
    assign w_funct = i_instr[5:0];
    assign w_rs    = i_instr[25:21];
    assign w_rtype = (w_op == 6'h00);

    assign w_addu  = w_rtype && (w_funct == 6'h21);
    assign w_subu  = w_rtype && (w_funct == 6'h23);
    assign w_slt   = w_rtype && (w_funct == 6'h2A);
    assign w_jr    = w_rtype && (w_funct == 6'h08);
    assign w_addi  = (w_op == 6'h08);
    assign w_addiu = (w_op == 6'h09);
    assign w_ori   = (w_op == 6'h0D);
    assign w_lui   = (w_op == 6'h0F);
    assign w_lb    = (w_op == 6'h20);
    assign w_lh    = (w_op == 6'h21);
    assign w_lw    = (w_op == 6'h23);
    assign w_sb    = (w_op == 6'h28);
    assign w_sh    = (w_op == 6'h29);
    assign w_sw    = (w_op == 6'h2B);
    assign w_beq   = (w_op == 6'h04);
    assign w_bne   = (w_op == 6'h05);
    assign w_j     = (w_op == 6'h02);
    assign w_jal   = (w_op == 6'h03);
    assign w_cop0  = (w_op == 6'h10);
    assign w_mfc0  = w_cop0 && (w_rs == 5'h00);
    assign w_mtc0  = w_cop0 && (w_rs == 5'h04);
    assign w_eret  = w_cop0 && (w_rs == 5'h10) && (w_funct == 6'h18);

    assign w_load  = w_lw | w_lh | w_lb;
    assign w_store = w_sw | w_sh | w_sb;
    assign w_alu_r = w_addu | w_subu | w_slt;
    assign w_alu_i = w_ori | w_lui | w_addi | w_addiu;

    // Only the shift-amount/rt/rd fields are never looked at by control
    assign w_unused_instr = ^i_instr[20:6];

    // Interrupt request as seen at an instruction boundary
    assign w_irq_pend = (|(i_irq & i_irq_mask)) & i_ie & ~i_exl;

    assign w_mem_size = (w_lh | w_sh) ? 2'b01 :
                        (w_lb | w_sb) ? 2'b10 : 2'b00;

    // lui rides the add path: rs is $0 and the extender does the shift
    assign w_alu_op = w_subu ? 3'b001 :
                      w_ori  ? 3'b010 :
                      w_slt  ? 3'b011 : 3'b000;

    assign w_ext_op = w_ori ? 2'b00 :
                      w_lui ? 2'b10 : 2'b01;

    assign o_state = r_state;

    // State sequencing; the last cycle of every instruction samples irq
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (i_mem_ready) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (w_load | w_store)            r_state <= S_MADDR;
                    else if (w_alu_r | w_alu_i)      r_state <= S_EXE;
                    else if (w_mfc0 | w_mtc0)        r_state <= S_RWB;
                    else if (w_beq | w_bne | w_jr)   r_state <= S_BRANCH;
                    else if (w_j | w_jal | w_eret)   r_state <= S_JUMP;
`ifdef RI_TRAP_EN
                    else                             r_state <= S_EXC;
`else
                    else                             r_state <= S_FETCH;
`endif
                end
                S_MADDR: begin
                    r_state <= w_load ? S_MREAD : S_MWRITE;
                end
                S_MREAD: begin
                    if (i_mem_ready) r_state <= S_MWB;
                end
                S_MWRITE: begin
                    if (i_mem_ready) r_state <= w_irq_pend ? S_INT : S_FETCH;
                end
                S_EXE: begin
                    r_state <= S_RWB;
                end
                S_MWB, S_RWB, S_BRANCH, S_JUMP: begin
                    r_state <= w_irq_pend ? S_INT : S_FETCH;
                end
                S_INT, S_EXC: begin
                    r_state <= S_FETCH;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // Datapath strobes and selects; everything is forced idle while rst is high
    always_comb begin
        o_pc_wr    = 1'b0;
        o_ir_wr    = 1'b0;
        o_reg_wr   = 1'b0;
        o_cp0_we   = 1'b0;
        o_epc_wr   = 1'b0;
        o_mem_req  = 1'b0;
        o_mem_we   = 1'b0;
        o_mem_size = 2'b00;
        o_reg_dst  = 2'b00;
        o_wb_sel   = 2'b00;
        o_alu_src  = 1'b0;
        o_alu_op   = 3'b000;
        o_ext_op   = 2'b00;
        o_pc_sel   = 3'b000;
        o_epc_sel  = 1'b0;
        o_exl_set  = 1'b0;
        o_exl_clr  = 1'b0;
        o_exc_code = '0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    o_mem_req = 1'b1;
                    if (i_mem_ready) begin
                        o_ir_wr  = 1'b1;
                        o_pc_wr  = 1'b1;
                        o_pc_sel = 3'b000;
                    end
                end
                S_MADDR: begin
                    o_alu_src = 1'b1;
                    o_ext_op  = 2'b01;
                    o_alu_op  = 3'b000;
                end
                S_MREAD: begin
                    o_mem_req  = 1'b1;
                    o_mem_size = w_mem_size;
                end
                S_MWB: begin
                    o_reg_wr  = 1'b1;
                    o_reg_dst = 2'b01;
                    o_wb_sel  = 2'b01;
                end
                S_MWRITE: begin
                    o_mem_req  = 1'b1;
                    o_mem_we   = 1'b1;
                    o_mem_size = w_mem_size;
                end
                S_EXE: begin
                    o_alu_src = w_alu_i;
                    o_ext_op  = w_ext_op;
                    o_alu_op  = w_alu_op;
                end
                S_RWB: begin
                    if (w_mtc0) begin
                        o_cp0_we = 1'b1;
                    end else if (w_mfc0) begin
                        o_reg_wr  = 1'b1;
                        o_wb_sel  = 2'b11;
                        o_reg_dst = 2'b01;
                    end else begin
                        o_reg_wr  = 1'b1;
                        o_reg_dst = w_alu_i ? 2'b01 : 2'b00;
                    end
                end
                S_BRANCH: begin
                    o_alu_op = 3'b001;
                    o_pc_wr  = w_beq ? i_zero : (w_bne ? ~i_zero : 1'b1);
                    o_pc_sel = w_jr ? 3'b011 : 3'b001;
                end
                S_JUMP: begin
                    o_pc_wr = 1'b1;
                    if (w_eret) begin
                        o_pc_sel  = 3'b100;
                        o_exl_clr = 1'b1;
                    end else begin
                        o_pc_sel = 3'b010;
                        if (w_jal) begin
                            o_reg_wr  = 1'b1;
                            o_reg_dst = 2'b10;
                            o_wb_sel  = 2'b10;
                        end
                    end
                end
                S_INT: begin
                    o_epc_wr   = 1'b1;
                    o_epc_sel  = 1'b0;
                    o_exl_set  = 1'b1;
                    o_exc_code = EXC_CODE_W'(0);
                    o_pc_wr    = 1'b1;
                    o_pc_sel   = 3'b101;
                end
`ifdef RI_TRAP_EN
                S_EXC: begin
                    o_epc_wr   = 1'b1;
                    o_epc_sel  = 1'b1;
                    o_exl_set  = 1'b1;
                    o_exc_code = EXC_CODE_W'(10);
                    o_pc_wr    = 1'b1;
                    o_pc_sel   = 3'b101;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl_irq.sv
// ============================================================================
//  Module      : tb_mc_ctrl_irq
//  Description : Self-checking bench for mc_ctrl_irq. Builds the expected
//                per-cycle output trace of each instruction from its
//                mnemonic and feeds a negedge compare process.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mc_ctrl_irq;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_wr, ir_wr, reg_wr, cp0_we, epc_wr, mem_req, mem_we;
        logic [1:0] mem_size, reg_dst, wb_sel;
        logic       alu_src;
        logic [2:0] alu_op;
        logic [1:0] ext_op;
        logic [2:0] pc_sel;
        logic       epc_sel, exl_set, exl_clr;
        logic [4:0] exc_code;
    } obs_t;

    typedef struct packed {
        logic rdy;
        obs_t o;
    } step_t;

    typedef enum {M_ADDU, M_SUBU, M_SLT, M_JR, M_ADDI, M_ADDIU, M_ORI, M_LUI,
                  M_LW, M_LH, M_LB, M_SW, M_SH, M_SB, M_BEQ, M_BNE, M_J, M_JAL,
                  M_MFC0, M_MTC0, M_ERET, M_BAD} mn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_instr = '0;
    logic        i_zero = 1'b0;
    logic [5:0]  i_irq = '0;
    logic [5:0]  i_irq_mask = '0;
    logic        i_ie = 1'b0;
    logic        i_exl = 1'b0;
    logic        i_mem_ready = 1'b0;

    logic [3:0] o_state;
    logic       o_pc_wr, o_ir_wr, o_reg_wr, o_cp0_we, o_epc_wr, o_mem_req, o_mem_we;
    logic [1:0] o_mem_size, o_reg_dst, o_wb_sel;
    logic       o_alu_src;
    logic [2:0] o_alu_op;
    logic [1:0] o_ext_op;
    logic [2:0] o_pc_sel;
    logic       o_epc_sel, o_exl_set, o_exl_clr;
    logic [4:0] o_exc_code;

    obs_t  act;
    obs_t  e_cur;
    obs_t  exp_q[$];
    step_t trace[$];
    string tag = "reset";
    int    n_vec = 0;
    int    n_err = 0;

    mc_ctrl_irq #(.NIRQ(6), .EXC_CODE_W(5)) dut (
        .clk(clk), .rst(rst), .i_instr(i_instr), .i_zero(i_zero),
        .i_irq(i_irq), .i_irq_mask(i_irq_mask), .i_ie(i_ie), .i_exl(i_exl),
        .i_mem_ready(i_mem_ready), .o_state(o_state), .o_pc_wr(o_pc_wr),
        .o_ir_wr(o_ir_wr), .o_reg_wr(o_reg_wr), .o_cp0_we(o_cp0_we),
        .o_epc_wr(o_epc_wr), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_size(o_mem_size), .o_reg_dst(o_reg_dst), .o_wb_sel(o_wb_sel),
        .o_alu_src(o_alu_src), .o_alu_op(o_alu_op), .o_ext_op(o_ext_op),
        .o_pc_sel(o_pc_sel), .o_epc_sel(o_epc_sel), .o_exl_set(o_exl_set),
        .o_exl_clr(o_exl_clr), .o_exc_code(o_exc_code)
    );

    assign act = {o_state, o_pc_wr, o_ir_wr, o_reg_wr, o_cp0_we, o_epc_wr,
                  o_mem_req, o_mem_we, o_mem_size, o_reg_dst, o_wb_sel,
                  o_alu_src, o_alu_op, o_ext_op, o_pc_sel, o_epc_sel,
                  o_exl_set, o_exl_clr, o_exc_code};

    always #5 clk = ~clk;

    // Compare the DUT against the model trace once per cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e_cur = exp_q.pop_front();
            n_vec++;
            if (act !== e_cur) begin
                n_err++;
                $display("FAIL %s trace: got st=%0d obs=%h expected st=%0d obs=%h",
                         tag, act.st, act, e_cur.st, e_cur);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic mn_t mnem(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        op = ins[31:26];
        fn = ins[5:0];
        rs = ins[25:21];
        case (op)
            6'h00: case (fn)
                       6'h21: return M_ADDU;
                       6'h23: return M_SUBU;
                       6'h2A: return M_SLT;
                       6'h08: return M_JR;
                       default: return M_BAD;
                   endcase
            6'h08: return M_ADDI;
            6'h09: return M_ADDIU;
            6'h0D: return M_ORI;
            6'h0F: return M_LUI;
            6'h23: return M_LW;
            6'h21: return M_LH;
            6'h20: return M_LB;
            6'h2B: return M_SW;
            6'h29: return M_SH;
            6'h28: return M_SB;
            6'h04: return M_BEQ;
            6'h05: return M_BNE;
            6'h02: return M_J;
            6'h03: return M_JAL;
            6'h10: begin
                if (rs == 5'h00) return M_MFC0;
                if (rs == 5'h04) return M_MTC0;
                if (rs == 5'h10 && fn == 6'h18) return M_ERET;
                return M_BAD;
            end
            default: return M_BAD;
        endcase
    endfunction

    function automatic obs_t idle(input logic [3:0] s);
        obs_t e;
        e = '0;
        e.st = s;
        return e;
    endfunction

    task automatic add(input obs_t o, input logic rdy);
        step_t s;
        s.rdy = rdy;
        s.o   = o;
        trace.push_back(s);
    endtask

    // Expected cycle-by-cycle trace of one instruction, from fetch to the
    // cycle before the next fetch. nz drives mem_ready high in cycles where
    // it must be ignored.
    task automatic build(input logic [31:0] ins, input int fst, input int mst,
                         input logic z, input logic pend, input logic nz);
        mn_t        m;
        obs_t       e;
        logic       fin;
        logic       ld, stq, imm;
        logic [1:0] sz;
        m   = mnem(ins);
        fin = 1'b1;
        ld  = (m == M_LW || m == M_LH || m == M_LB);
        stq = (m == M_SW || m == M_SH || m == M_SB);
        imm = (m == M_ADDI || m == M_ADDIU || m == M_ORI || m == M_LUI);
        sz  = (m == M_LH || m == M_SH) ? 2'b01 : (m == M_LB || m == M_SB) ? 2'b10 : 2'b00;
        trace.delete();
        for (int k = 0; k < fst; k++) begin
            e = idle(4'd0); e.mem_req = 1'b1; add(e, 1'b0);
        end
        e = idle(4'd0); e.mem_req = 1'b1; e.ir_wr = 1'b1; e.pc_wr = 1'b1; add(e, 1'b1);
        add(idle(4'd1), nz);
        if (ld || stq) begin
            e = idle(4'd2); e.alu_src = 1'b1; e.ext_op = 2'b01; add(e, nz);
            e = idle(ld ? 4'd3 : 4'd5);
            e.mem_req = 1'b1; e.mem_we = stq; e.mem_size = sz;
            for (int k = 0; k < mst; k++) add(e, 1'b0);
            add(e, 1'b1);
            if (ld) begin
                e = idle(4'd4); e.reg_wr = 1'b1; e.reg_dst = 2'b01; e.wb_sel = 2'b01; add(e, nz);
            end
        end else if (imm || m == M_ADDU || m == M_SUBU || m == M_SLT) begin
            e = idle(4'd6);
            e.alu_src = imm;
            e.ext_op  = (m == M_ORI) ? 2'b00 : (m == M_LUI) ? 2'b10 : 2'b01;
            e.alu_op  = (m == M_SUBU) ? 3'd1 : (m == M_ORI) ? 3'd2 : (m == M_SLT) ? 3'd3 : 3'd0;
            add(e, nz);
            e = idle(4'd7); e.reg_wr = 1'b1; e.reg_dst = imm ? 2'b01 : 2'b00; add(e, nz);
        end else if (m == M_MFC0) begin
            e = idle(4'd7); e.reg_wr = 1'b1; e.wb_sel = 2'b11; e.reg_dst = 2'b01; add(e, nz);
        end else if (m == M_MTC0) begin
            e = idle(4'd7); e.cp0_we = 1'b1; add(e, nz);
        end else if (m == M_BEQ || m == M_BNE || m == M_JR) begin
            e = idle(4'd8); e.alu_op = 3'd1;
            e.pc_wr  = (m == M_BEQ) ? z : (m == M_BNE) ? !z : 1'b1;
            e.pc_sel = (m == M_JR) ? 3'd3 : 3'd1;
            add(e, nz);
        end else if (m == M_J || m == M_JAL || m == M_ERET) begin
            e = idle(4'd9); e.pc_wr = 1'b1;
            e.pc_sel  = (m == M_ERET) ? 3'd4 : 3'd2;
            e.exl_clr = (m == M_ERET);
            if (m == M_JAL) begin
                e.reg_wr = 1'b1; e.reg_dst = 2'b10; e.wb_sel = 2'b10;
            end
            add(e, nz);
        end else begin
            fin = 1'b0;
`ifdef RI_TRAP_EN
            e = idle(4'd11); e.epc_wr = 1'b1; e.epc_sel = 1'b1; e.exl_set = 1'b1;
            e.exc_code = 5'd10; e.pc_wr = 1'b1; e.pc_sel = 3'd5;
            add(e, nz);
`endif
        end
        if (fin && pend) begin
            e = idle(4'd10); e.epc_wr = 1'b1; e.exl_set = 1'b1; e.pc_wr = 1'b1; e.pc_sel = 3'd5;
            add(e, nz);
        end
    endtask

    task automatic run(input string t, input logic [31:0] ins, input int fst, input int mst,
                       input logic z, input logic [5:0] irq, input logic [5:0] msk,
                       input logic ie, input logic exl, input logic nz);
        logic pend;
        pend = ((irq & msk) != 6'd0) && ie && !exl;
        build(ins, fst, mst, z, pend, nz);
        foreach (trace[i]) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                tag = t; i_instr = ins; i_zero = z; i_irq = irq;
                i_irq_mask = msk; i_ie = ie; i_exl = exl;
            end
            i_mem_ready = trace[i].rdy;
            exp_q.push_back(trace[i].o);
        end
    endtask

    task automatic step(input logic rdy);
        @(posedge clk);
        #1;
        i_mem_ready = rdy;
        @(negedge clk);
    endtask

    localparam logic [31:0] C_LH    = {6'h21, 5'd16, 5'd8, 16'd2};
    localparam logic [31:0] C_LW    = {6'h23, 5'd16, 5'd8, 16'd8};
    localparam logic [31:0] C_LB    = {6'h20, 5'd16, 5'd8, 16'd3};
    localparam logic [31:0] C_SW    = {6'h2B, 5'd16, 5'd8, 16'd4};
    localparam logic [31:0] C_SH    = {6'h29, 5'd16, 5'd8, 16'd6};
    localparam logic [31:0] C_SB    = {6'h28, 5'd16, 5'd8, 16'd1};
    localparam logic [31:0] C_ADDU  = {6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h21};
    localparam logic [31:0] C_SUBU  = {6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h23};
    localparam logic [31:0] C_SLT   = {6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h2A};
    localparam logic [31:0] C_JR    = {6'h00, 5'd31, 15'd0, 6'h08};
    localparam logic [31:0] C_ORI   = {6'h0D, 5'd9, 5'd8, 16'h00FF};
    localparam logic [31:0] C_LUI   = {6'h0F, 5'd0, 5'd8, 16'h1234};
    localparam logic [31:0] C_ADDI  = {6'h08, 5'd9, 5'd8, 16'hFFFF};
    localparam logic [31:0] C_ADDIU = {6'h09, 5'd9, 5'd8, 16'h0010};
    localparam logic [31:0] C_BEQ   = {6'h04, 5'd8, 5'd9, 16'h0010};
    localparam logic [31:0] C_BNE   = {6'h05, 5'd8, 5'd9, 16'h0010};
    localparam logic [31:0] C_J     = {6'h02, 26'h0000100};
    localparam logic [31:0] C_JAL   = {6'h03, 26'h0000200};
    localparam logic [31:0] C_MFC0  = {6'h10, 5'h00, 5'd8, 5'd14, 11'd0};
    localparam logic [31:0] C_MTC0  = {6'h10, 5'h04, 5'd8, 5'd12, 11'd0};
    localparam logic [31:0] C_ERET  = 32'h4200_0018;
    localparam logic [31:0] C_BAD   = {6'h3F, 26'h0};

    initial begin
        // Reset: everything idle, state FETCH
        @(negedge clk);
        chk("reset state", {60'd0, o_state}, 64'd0);
        chk("reset outputs idle", {30'd0, act}, 64'd0);
        @(negedge clk);
        chk("reset mem_req held low", {63'd0, o_mem_req}, 64'd0);

        // Fetch stalls three cycles, then lh $t0,2($s0) walks to MREAD
        i_instr = C_LH;
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_mem_ready = 1'b0;
        @(negedge clk);
        chk("fetch stall1 state", {60'd0, o_state}, 64'd0);
        chk("fetch stall1 mem_req", {63'd0, o_mem_req}, 64'd1);
        step(1'b0);
        chk("fetch stall2 ir_wr", {63'd0, o_ir_wr}, 64'd0);
        step(1'b0);
        chk("fetch stall3 ir_wr", {63'd0, o_ir_wr}, 64'd0);
        chk("fetch stall3 state", {60'd0, o_state}, 64'd0);
        step(1'b1);
        chk("fetch ready ir_wr", {63'd0, o_ir_wr}, 64'd1);
        chk("fetch ready pc_wr", {63'd0, o_pc_wr}, 64'd1);
        step(1'b0);
        chk("lh decode state", {60'd0, o_state}, 64'd1);
        step(1'b0);
        chk("lh maddr state", {60'd0, o_state}, 64'd2);
        chk("lh maddr ext_op", {62'd0, o_ext_op}, 64'd1);
        step(1'b0);
        chk("lh mread state", {60'd0, o_state}, 64'd3);
        chk("lh mread mem_size", {62'd0, o_mem_size}, 64'd1);

        // Asynchronous reset mid-MREAD aborts the access at once
        #1;
        rst = 1'b1;
        #1;
        chk("rst mid-mread state", {60'd0, o_state}, 64'd0);
        chk("rst mid-mread outputs idle", {30'd0, act}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst state", {60'd0, o_state}, 64'd0);
        chk("post-rst mem_req", {63'd0, o_mem_req}, 64'd1);

        // Model-checked directed instructions: tag, instr, fetch stall, mem stall,
        // zero, irq, mask, ie, exl, mem_ready noise
        run("lh imm",          C_LH,    0, 0, 0, 6'h00, 6'h00, 0, 0, 0);
        run("lw stalls noise", C_LW,    2, 3, 0, 6'h00, 6'h00, 0, 0, 1);
        run("lb",              C_LB,    1, 1, 0, 6'h00, 6'h3F, 1, 0, 0);
        run("sw",              C_SW,    0, 2, 0, 6'h00, 6'h00, 0, 0, 1);
        run("sh irq int",      C_SH,    0, 1, 0, 6'h01, 6'h01, 1, 0, 0);
        run("sb",              C_SB,    1, 0, 0, 6'h00, 6'h00, 0, 0, 0);
        run("bne zero1",       C_BNE,   0, 0, 1, 6'h00, 6'h00, 0, 0, 0);
        run("bne zero0",       C_BNE,   0, 0, 0, 6'h00, 6'h00, 0, 0, 0);
        run("beq zero1",       C_BEQ,   0, 0, 1, 6'h00, 6'h00, 0, 0, 1);
        run("beq zero0",       C_BEQ,   0, 0, 0, 6'h00, 6'h00, 0, 0, 0);
        run("jr",              C_JR,    0, 0, 0, 6'h00, 6'h00, 0, 0, 0);
        run("addu irq int",    C_ADDU,  0, 0, 0, 6'b000100, 6'b000100, 1, 0, 0);
        run("addu irq exl",    C_ADDU,  0, 0, 0, 6'b000100, 6'b000100, 1, 1, 0);
        run("addu masked",     C_ADDU,  0, 0, 0, 6'b000100, 6'b111011, 1, 0, 0);
        run("addu ie0",        C_ADDU,  0, 0, 0, 6'b000100, 6'b000100, 0, 0, 0);
        run("subu",            C_SUBU,  0, 0, 0, 6'h00, 6'h00, 0, 0, 1);
        run("slt",             C_SLT,   1, 0, 0, 6'h00, 6'h00, 0, 0, 0);
        run("ori",             C_ORI,   0, 0, 0, 6'h00, 6'h00, 0, 0, 0);
        run("lui",             C_LUI,   0, 0, 0, 6'h00, 6'h00, 0, 0, 0);
        run("addi",            C_ADDI,  0, 0, 0, 6'h00, 6'h00, 0, 0, 0);
        run("addiu irq",       C_ADDIU, 0, 0, 0, 6'h20, 6'h20, 1, 0, 0);
        run("mfc0",            C_MFC0,  0, 0, 0, 6'h00, 6'h00, 0, 0, 0);
        run("mtc0",            C_MTC0,  0, 0, 0, 6'h00, 6'h00, 0, 0, 1);
        run("j",               C_J,     0, 0, 0, 6'h00, 6'h00, 0, 0, 0);
        run("jal irq",         C_JAL,   0, 0, 0, 6'h02, 6'h02, 1, 0, 0);
        run("eret exl",        C_ERET,  0, 0, 0, 6'h3F, 6'h3F, 1, 1, 0);
        run("undecoded",       C_BAD,   0, 0, 0, 6'h3F, 6'h3F, 1, 0, 0);
        run("lw after bad",    C_LW,    0, 0, 0, 6'h00, 6'h00, 0, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("trace drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
